// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between N input streams and the single registered output stream.
// The slave modport is the multiplexer's view; master is the surrounding logic.
interface stream_mux_rr_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic            mode;
  logic [SW-1:0]   sel;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_chan;
  logic            out_valid;
  logic            out_ready;

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N-to-1 stream multiplexer with fixed-select or round-robin arbitration and a
// one-entry registered output stage that sustains one beat per cycle.
module stream_mux_rr #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  stream_mux_rr_if.slave    bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_chan_q,  out_chan_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] ptr_q,       ptr_d;

  logic          load_en;
  logic          grant_vld;
  logic [SW-1:0] grant_idx;
  logic          xfer;

  assign load_en = !out_valid_q || bus.out_ready;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    if (!bus.mode) begin
      // Comparing against each legal index means an out-of-range sel simply never matches.
      for (int i = 0; i < N; i++) begin
        if (bus.sel == SW'(i) && bus.in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SW'(i);
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(ptr_q) + k) % N;
        if (!grant_vld && bus.in_valid[idx]) begin
          grant_vld = 1'b1;
          grant_idx = SW'(idx);
        end
      end
    end
  end

  // rst_n gates the handshake so no upstream beat is accepted while the register is held clear.
  assign xfer = rst_n && load_en && grant_vld;

  always_comb begin
    bus.in_ready = '0;
    if (xfer) bus.in_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = bus.in_data[int'(grant_idx)*W +: W];
      out_chan_d  = grant_idx;
      out_valid_d = 1'b1;
      ptr_d       = grant_idx;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: the data register is reset as well so out_data reads a defined zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SW'(N - 1);
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: stimulus pushes expected beats into a queue,
// a negedge monitor pops and compares every beat the output stage hands downstream.
module tb_stream_mux_rr;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_mux_rr_if #(.N(4), .W(8)) bus4 ();
  stream_mux_rr_if #(.N(3), .W(8)) bus3 ();

  stream_mux_rr #(.N(4), .W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  stream_mux_rr #(.N(3), .W(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  typedef struct {
    logic [1:0] chan;
    logic [7:0] data;
  } beat_t;

  beat_t sb_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  function automatic logic [7:0] ch_data(input int i);
    return 8'hA0 + 8'(i * 17);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Downstream accepts a beat at the edge following a negedge where valid && ready.
  always @(negedge clk) begin : monitor
    beat_t e;
    if (rst_n && bus4.out_valid && bus4.out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("sb_chan", 32'(bus4.out_chan), 32'(e.chan));
        check("sb_data", 32'(bus4.out_data), 32'(e.data));
      end
    end
  end

  // One cycle on the N=4 instance: drive, check in_ready, record expected beat, cross the edge.
  task automatic step(input logic m, input logic [1:0] s, input logic [3:0] v, input logic r,
                      input logic [3:0] exp_rdy, input int exp_chan, input string name);
    beat_t b;
    bus4.mode      = m;
    bus4.sel       = s;
    bus4.in_valid  = v;
    bus4.out_ready = r;
    #1;
    check({name, "_rdy"}, 32'(bus4.in_ready), 32'(exp_rdy));
    if (exp_chan >= 0) begin
      b.chan = 2'(exp_chan);
      b.data = ch_data(exp_chan);
      sb_q.push_back(b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic v, input logic [1:0] c, input logic [7:0] d);
    check({name, "_valid"}, 32'(bus4.out_valid), 32'(v));
    check({name, "_chan"},  32'(bus4.out_chan),  32'(c));
    check({name, "_data"},  32'(bus4.out_data),  32'(d));
  endtask

  initial begin
    static int skip_seq[4] = '{1, 3, 1, 3};

    bus4.in_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    bus4.mode      = 1'b1;
    bus4.sel       = '0;
    bus4.in_valid  = 4'hF;
    bus4.out_ready = 1'b1;
    bus3.in_data   = {8'hC2, 8'hB1, 8'hA0};
    bus3.mode      = 1'b0;
    bus3.sel       = '0;
    bus3.in_valid  = '0;
    bus3.out_ready = 1'b1;

    // Reset state, with every input requesting so in_ready gating is exercised.
    #2;
    check_out("reset", 1'b0, 2'd0, 8'h00);
    check("reset_rdy", 32'(bus4.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Round-robin fairness from reset: 0,1,2,3,0,1,2,3 with a beat every cycle.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 2'd0, 4'hF, 1'b1, 4'(1 << (k % 4)), k % 4, "rr_fair");
      check("rr_fair_valid", 32'(bus4.out_valid), 32'd1);
    end

    // Fixed select, switching sel cycle to cycle.
    step(1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 2, "fix_sel2");
    step(1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 0, "fix_sel0");

    // Round-robin skipping idle channels 0 and 2.
    for (int k = 0; k < 4; k++)
      step(1'b1, 2'd0, 4'b1010, 1'b1, 4'(1 << skip_seq[k]), skip_seq[k], "rr_skip");

    // Backpressure: load channel 1, stall three cycles, then resume at channel 2.
    step(1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1, "bp_load");
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, -1, "bp_stall");
      check_out("bp_hold", 1'b1, 2'd1, 8'hB1);
    end
    step(1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 2, "bp_resume");

    // Pointer survives a mode change: fixed grant on 3, then round-robin continues at 0.
    step(1'b0, 2'd3, 4'hF, 1'b1, 4'b1000, 3, "msw_fix3");
    step(1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 0, "msw_rr");

    // Idle drain: valid drops, data keeps the last beat.
    step(1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, -1, "idle");
    check_out("idle_out", 1'b0, 2'd0, 8'hA0);

    // Asynchronous reset with a beat held in the output register; the beat is dropped.
    step(1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1, "rst_pre");
    rst_n = 1'b0;
    #1;
    check_out("rst_async", 1'b0, 2'd0, 8'h00);
    check("rst_async_rdy", 32'(bus4.in_ready), 32'd0);
    check("rst_discard_pending", 32'(sb_q.size()), 32'd1);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 0, "rst_first");
    step(1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, -1, "rst_drain");

    // N=3 instance: a legal select, then sel=3 which must never grant.
    bus3.mode     = 1'b0;
    bus3.sel      = 2'd1;
    bus3.in_valid = 3'b111;
    #1;
    check("n3_sel1_rdy", 32'(bus3.in_ready), 32'b010);
    @(posedge clk);
    #1;
    check("n3_sel1_valid", 32'(bus3.out_valid), 32'd1);
    check("n3_sel1_chan",  32'(bus3.out_chan),  32'd1);
    check("n3_sel1_data",  32'(bus3.out_data),  32'hB1);
    bus3.sel = 2'd3;
    #1;
    check("n3_sel3_rdy", 32'(bus3.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("n3_sel3_valid", 32'(bus3.out_valid), 32'd0);
    check("n3_sel3_data",  32'(bus3.out_data),  32'hB1);

    repeat (2) @(posedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 SHALL have parameter N, default 4, number of input channels (2..16).
REQ-002 SHALL have parameter W, default 8, data width per channel (1..64).
REQ-003 SHALL have localparam SW = max(1, clog2(N)), the channel-index width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; it is asynchronous and active-low.
REQ-006 SHALL have port mode, input, 1, arbitration mode: 0 = fixed select, 1 = round-robin.
REQ-007 SHALL have port sel, input, SW, the channel index used when mode=0.
REQ-008 SHALL have port in_data, input, N*W, with channel i at bits [i*W+W-1 : i*W].
REQ-009 SHALL have port in_valid, input, N, the per-channel valid.
REQ-010 SHALL have port in_ready, output, N, the per-channel ready (combinational).
REQ-011 SHALL have port out_data, output, W, the registered selected data.
REQ-012 SHALL have port out_chan, output, SW, the registered index of the channel that supplied out_data.
REQ-013 SHALL have port out_valid, output, 1, the registered output valid.
REQ-014 SHALL have port out_ready, input, 1, downstream ready.

Function
REQ-015 SHALL implement a one-entry output register; load_en = !out_valid || out_ready.
REQ-016 SHALL compute one grant per cycle, combinationally:
- mode=0: grant = sel when sel < N and in_valid[sel]=1; otherwise no grant.
- mode=1: grant = the first i with in_valid[i]=1, searching cyclically from (ptr+1) mod N; no grant if in_valid = 0.
REQ-017 SHALL drive in_ready[i] = load_en && grant valid && grant == i; all other in_ready bits are 0, so at most one bit is high.
REQ-018 SHALL treat an input transfer as in_valid[i] && in_ready[i]. On a transfer, the next edge loads out_data = channel i data, out_chan = i and out_valid = 1 (latency 1 cycle).
REQ-019 SHALL clear out_valid on the next edge when out_valid && out_ready and no input transfer occurs.
REQ-020 SHALL hold out_data, out_chan and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL sustain one beat per cycle when out_ready is held at 1 and a grant exists.
REQ-022 SHALL update the round-robin pointer ptr (SW bits) to the granted index only on an input transfer, in either mode; ptr is otherwise held.
REQ-023 SHALL apply mode and sel changes on the same cycle's arbitration, with no state flush; ptr is retained across mode changes.
REQ-024 SHALL produce no grant and no in_ready when sel >= N (non-power-of-two N) in mode=0.
REQ-025 SHALL ignore in_data of non-granted channels, and channels whose in_valid=0.
REQ-026 SHALL be free of combinational loops. Combinational paths out_ready->in_ready and in_valid->in_ready are permitted; all outputs other than in_ready come from registers.

Reset
REQ-027 SHALL, while rst_n=0, force out_valid=0, out_data=0, out_chan=0 and ptr=N-1, so that the first round-robin search starts at channel 0.
REQ-028 SHALL hold in_ready=0 while rst_n=0.
REQ-029 SHALL, on reset assertion mid-transfer, discard the beat held in the output register; it is not replayed.
REQ-030 SHALL allow the first transfer on the first rising edge after rst_n deasserts.

Verification
REQ-031 Fixed select: N=4, W=8, mode=0, sel=2, in_data={8'hD3,8'hC2,8'hB1,8'hA0}, in_valid=4'b1111, out_ready=1 -> in_ready=4'b0100; after 1 edge out_data=8'hC2, out_chan=2, out_valid=1.
REQ-032 Round-robin fairness: mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles from reset -> out_chan sequence 0,1,2,3,0,1,2,3 with out_valid=1 every cycle.
REQ-033 Round-robin skip: mode=1, in_valid=4'b1010, out_ready=1 -> out_chan alternates 1,3,1,3; in_ready[0] and in_ready[2] are never 1.
REQ-034 Backpressure: a beat is loaded (out_chan=1, out_data=8'hB1), then out_ready=0 for 3 cycles with all inputs valid -> out_data, out_chan and out_valid are unchanged and in_ready=0 throughout; ptr is unchanged. When out_ready=1, the next grant is channel 2.
REQ-035 Invalid select and reset: N=3, mode=0, sel=3 -> in_ready=0 and out_valid falls to 0 after draining. Asserting rst_n=0 asynchronously mid-stream -> out_valid=0 and out_data=0 immediately without a clock edge; after release the first round-robin grant is channel 0.
REQ-036 Idle drain: out_valid=1, out_ready=1, in_valid=0 -> out_valid=0 after 1 edge; out_data holds its last value.
